// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Shares one UART transmitter between NREQ byte-stream requesters. Each
//   packet is granted in round-robin order and keeps the grant until its
//   last byte. The transmitter is driven through a start/busy handshake, and
//   an idle gap of GAP_CYCLES clocks follows each completed packet.
//
//   State table:
//     IDLE      | nothing pending, or transmitter still busy
//     SEL       | choosing a requester (or waiting on the locked owner)
//     WAIT_BUSY | tx_start issued, waiting for the transmitter to go busy
//     WAIT_DONE | frame in flight, waiting for the transmitter to finish
//     GAP       | idle gap after a packet's last byte
//
// Ports:
//   clk, rst                 system clock, async active-high reset
//   req_valid/data/last      per-requester byte stream (slice i of req_data)
//   req_ready                one-cycle pulse: byte of requester i accepted
//   tx_start, tx_data        one-cycle start pulse and byte to the transmitter
//   tx_busy                  transmitter is shifting a frame
//   grant                    one-hot lock owner, 0 when unlocked
//   sched_busy               high whenever not IDLE
//   timeout_err              one-cycle pulse when a lock is revoked by timeout
module uart_tx_sched #(
  parameter int NREQ         = 4,
  parameter int DATA_W       = 8,
  parameter int GAP_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic                   tx_start,
  output logic [DATA_W-1:0]      tx_data,
  input  logic                   tx_busy,
  output logic [NREQ-1:0]        grant,
  output logic                   sched_busy,
  output logic                   timeout_err
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  typedef enum logic [2:0] {IDLE, SEL, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  owner;
  logic              locked;
  logic              last_flag;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TO_W-1:0]   to_cnt;

  logic [IDX_W-1:0]  scan_idx;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              any_valid;

  // Round-robin search starting just after rr_ptr, wrapping NREQ-1 -> 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // While locked only the owner is a candidate.
  assign sel_idx   = locked ? owner : pick_idx;
  assign sel_valid = locked ? req_valid[owner] : pick_found;
  assign sel_data  = req_data[int'(sel_idx)*DATA_W +: DATA_W];
  assign any_valid = |req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= LAST_IDX;
      owner       <= '0;
      locked      <= 1'b0;
      last_flag   <= 1'b0;
      gap_cnt     <= '0;
      to_cnt      <= '0;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant       <= '0;
      sched_busy  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      req_ready   <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid && !tx_busy) begin
            state      <= SEL;
            sched_busy <= 1'b1;
          end
        end
        SEL: begin
          if (sel_valid && !tx_busy) begin
            tx_data   <= sel_data;
            tx_start  <= 1'b1;
            req_ready <= {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
            grant     <= {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
            owner     <= sel_idx;
            locked    <= 1'b1;
            last_flag <= req_last[sel_idx];
            to_cnt    <= '0;
            state     <= WAIT_BUSY;
          end else if (locked) begin
            if (req_valid[owner]) begin
              to_cnt <= '0;
            end else if (to_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
              // Owner went quiet mid-packet: revoke without an idle gap.
              timeout_err <= 1'b1;
              locked      <= 1'b0;
              rr_ptr      <= owner;
              grant       <= '0;
              to_cnt      <= '0;
              if (!any_valid) begin
                state      <= IDLE;
                sched_busy <= 1'b0;
              end
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end else if (!any_valid) begin
            state      <= IDLE;
            sched_busy <= 1'b0;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_flag) begin
              locked <= 1'b0;
              rr_ptr <= owner;
              grant  <= '0;
              if (GAP_CYCLES > 0) begin
                state   <= GAP;
                gap_cnt <= GAP_W'(GAP_CYCLES);
              end else if (any_valid) begin
                state <= SEL;
              end else begin
                state      <= IDLE;
                sched_busy <= 1'b0;
              end
            end else begin
              state <= SEL;
            end
          end
        end
        GAP: begin
          // Down-count; GAP lasts exactly GAP_CYCLES clocks.
          if (gap_cnt == GAP_W'(1)) begin
            if (any_valid) begin
              state <= SEL;
            end else begin
              state      <= IDLE;
              sched_busy <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          sched_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: requester queues and a transmitter model run
// on the falling edge; each test task loads packets, lets a high-level
// round-robin/packet model predict the byte order, and checks order, grant,
// and tx_start spacing (frame + handshake, plus the gap after last bytes).
module tb_uart_tx_sched;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int GAP  = 16;
  localparam int LTO  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid, req_last, req_ready, grant;
  logic [NREQ*DW-1:0] req_data;
  logic            tx_start, tx_busy, sched_busy, timeout_err;
  logic [DW-1:0]   tx_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int frame_len = 10;
  int busy_cnt = 0;
  int busy_fall_cyc = 0;
  int idle_fall_cyc = 0;
  bit prev_sb = 1'b0;
  int model_rr = NREQ - 1;

  typedef struct {int req; logic [DW-1:0] data; bit last;} ent_t;
  typedef struct {int cyc; int req; logic [DW-1:0] data; logic [NREQ-1:0] grant;} ev_t;
  typedef struct {int cyc; logic [NREQ-1:0] grant;} to_t;

  ent_t pend[$];
  ent_t load_q[$];
  ent_t exp_q[$];
  ev_t  ev_q[$];
  to_t  to_q[$];

  uart_tx_sched #(.NREQ(NREQ), .DATA_W(DW), .GAP_CYCLES(GAP), .LOCK_TIMEOUT(LTO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .grant(grant),
    .sched_busy(sched_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [NREQ-1:0] v);
    int r = -1;
    int n = 0;
    for (int i = 0; i < NREQ; i++) if (v[i]) begin r = i; n++; end
    return (n == 1) ? r : -1;
  endfunction

  // Environment: transmitter model, event monitor and requesters.
  initial begin
    req_valid = '0; req_last = '0; req_data = '0; tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_busy) begin
        busy_cnt--;
        if (busy_cnt <= 0) begin tx_busy = 1'b0; busy_fall_cyc = cyc; end
      end
      if (tx_start) begin
        ev_t e;
        e.cyc = cyc; e.req = idx_of(req_ready); e.data = tx_data; e.grant = grant;
        ev_q.push_back(e);
        tx_busy = 1'b1;
        busy_cnt = frame_len;
      end
      if (timeout_err) begin
        to_t t;
        t.cyc = cyc; t.grant = grant;
        to_q.push_back(t);
      end
      if (prev_sb && !sched_busy) idle_fall_cyc = cyc;
      prev_sb = sched_busy;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          int h;
          h = -1;
          foreach (pend[j]) if (h < 0 && pend[j].req == i) h = j;
          if (h >= 0) pend.delete(h);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        int h;
        h = -1;
        foreach (pend[j]) if (h < 0 && pend[j].req == i) h = j;
        if (h >= 0) begin
          req_valid[i] = 1'b1; req_data[i*DW +: DW] = pend[h].data; req_last[i] = pend[h].last;
        end else begin
          req_valid[i] = 1'b0; req_data[i*DW +: DW] = '0; req_last[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load(input int r, input logic [DW-1:0] d, input bit l);
    ent_t e;
    e.req = r; e.data = d; e.last = l;
    pend.push_back(e);
    load_q.push_back(e);
  endtask

  // Packet-level round robin: next requester with pending bytes after the
  // last served one; its whole packet goes out before anyone else.
  task automatic run_model();
    ent_t rem[$];
    int r, pick;
    bit done;
    rem = load_q;
    exp_q.delete();
    while (rem.size() > 0) begin
      r = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (model_rr + k) % NREQ;
        if (r < 0) foreach (rem[j]) if (rem[j].req == c) r = c;
      end
      done = 1'b0;
      while (!done) begin
        pick = -1;
        foreach (rem[j]) if (pick < 0 && rem[j].req == r) pick = j;
        if (pick < 0) done = 1'b1;
        else begin
          exp_q.push_back(rem[pick]);
          done = rem[pick].last;
          rem.delete(pick);
        end
      end
      model_rr = r;
    end
    load_q.delete();
  endtask

  task automatic wait_events(input int n, input int budget);
    int t = 0;
    while (ev_q.size() < n && t < budget) begin @(negedge clk); #1; t++; end
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((sched_busy || tx_busy || pend.size() != 0) && t < budget) begin @(negedge clk); #1; t++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({req_ready, tx_start, tx_data, grant, sched_busy, timeout_err} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h, required 0",
        {req_ready, tx_start, tx_data, grant, sched_busy, timeout_err});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, tx_start, tx_data, grant, sched_busy, timeout_err} !== '0) begin
      errors++; $display("FAIL reset_held: got %h, required 0",
        {req_ready, tx_start, tx_data, grant, sched_busy, timeout_err});
    end
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sched_busy !== 1'b0 || grant !== '0) begin
      errors++; $display("FAIL idle_after_reset: sched_busy=%b grant=%b, required 0/0", sched_busy, grant);
    end
  endtask

  task automatic test_round_robin();
    ev_q.delete();
    @(negedge clk); #1;
    load(0, 8'($urandom_range(0, 255)), 1'b1);
    load(1, 8'($urandom_range(0, 255)), 1'b1);
    load(2, 8'($urandom_range(0, 255)), 1'b1);
    load(0, 8'($urandom_range(0, 255)), 1'b1);
    run_model();
    wait_events(exp_q.size(), 400);
    wait_idle(200);
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rr_count: got %0d bytes, required %0d", ev_q.size(), exp_q.size());
    end
    for (int k = 0; k < ev_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (ev_q[k].req !== exp_q[k].req || ev_q[k].data !== exp_q[k].data || ev_q[k].grant !== (NREQ'(1) << exp_q[k].req)) begin
        errors++; $display("FAIL rr_byte[%0d]: got req %0d data %h grant %b, required req %0d data %h",
          k, ev_q[k].req, ev_q[k].data, ev_q[k].grant, exp_q[k].req, exp_q[k].data);
      end
      if (k > 0) begin
        checks++;
        if (ev_q[k].cyc - ev_q[k-1].cyc != (exp_q[k-1].last ? frame_len + 2 + GAP : frame_len + 2)) begin
          errors++; $display("FAIL rr_spacing[%0d]: got %0d clocks, required %0d", k,
            ev_q[k].cyc - ev_q[k-1].cyc, exp_q[k-1].last ? frame_len + 2 + GAP : frame_len + 2);
        end
      end
    end
  endtask

  task automatic test_packet_lock();
    ev_q.delete();
    @(negedge clk); #1;
    load(1, 8'h11, 1'b0);
    load(1, 8'h22, 1'b0);
    load(1, 8'h33, 1'b1);
    load(2, 8'($urandom_range(0, 255)), 1'b1);
    run_model();
    wait_events(exp_q.size(), 400);
    wait_idle(200);
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++; $display("FAIL lock_count: got %0d bytes, required %0d", ev_q.size(), exp_q.size());
    end
    for (int k = 0; k < ev_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (ev_q[k].req !== exp_q[k].req || ev_q[k].data !== exp_q[k].data || ev_q[k].grant !== (NREQ'(1) << exp_q[k].req)) begin
        errors++; $display("FAIL lock_byte[%0d]: got req %0d data %h grant %b, required req %0d data %h",
          k, ev_q[k].req, ev_q[k].data, ev_q[k].grant, exp_q[k].req, exp_q[k].data);
      end
      if (k > 0) begin
        checks++;
        if (ev_q[k].cyc - ev_q[k-1].cyc != (exp_q[k-1].last ? frame_len + 2 + GAP : frame_len + 2)) begin
          errors++; $display("FAIL lock_spacing[%0d]: got %0d clocks, required %0d", k,
            ev_q[k].cyc - ev_q[k-1].cyc, exp_q[k-1].last ? frame_len + 2 + GAP : frame_len + 2);
        end
      end
    end
  endtask

  task automatic test_single_byte();
    int c0;
    ev_q.delete();
    @(negedge clk); #1;
    c0 = cyc;
    load(0, 8'hA5, 1'b1);
    run_model();
    wait_events(1, 50);
    checks++;
    if (ev_q.size() != 1 || ev_q[0].data !== 8'hA5 || ev_q[0].req != 0) begin
      errors++; $display("FAIL single_byte: got %0d pulses, required 1 with data a5 from req 0", ev_q.size());
    end
    if (ev_q.size() > 0) begin
      checks++;
      if (ev_q[0].cyc != c0 + 3) begin
        errors++; $display("FAIL single_latency: got tx_start at +%0d, required +3", ev_q[0].cyc - c0);
      end
      @(negedge clk); #1;
      checks++;
      if (tx_start !== 1'b0 || req_ready !== '0) begin
        errors++; $display("FAIL single_pulse: tx_start=%b req_ready=%b one cycle later, required 0", tx_start, req_ready);
      end
      wait_idle(100);
      checks++;
      if (idle_fall_cyc != ev_q[0].cyc + frame_len + 1 + GAP) begin
        errors++; $display("FAIL single_gap_idle: got sched_busy drop at +%0d, required +%0d",
          idle_fall_cyc - ev_q[0].cyc, frame_len + 1 + GAP);
      end
      checks++;
      if (grant !== '0) begin
        errors++; $display("FAIL single_grant_release: got %b, required 0", grant);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] b0, b1;
    int viol, t;
    ev_q.delete();
    frame_len = 50;
    b0 = 8'($urandom_range(1, 255));
    b1 = 8'($urandom_range(0, 255));
    @(negedge clk); #1;
    load(2, b0, 1'b0);
    load(2, b1, 1'b1);
    run_model();
    wait_events(1, 50);
    viol = 0; t = 0;
    while (tx_busy && t < 100) begin
      @(negedge clk); #1; t++;
      if (tx_busy && (tx_start !== 1'b0 || req_ready !== '0 || tx_data !== b0)) viol++;
    end
    checks++;
    if (viol != 0) begin
      errors++; $display("FAIL bp_hold: got %0d violating cycles while busy, required 0", viol);
    end
    wait_events(2, 100);
    wait_idle(200);
    checks++;
    if (ev_q.size() != 2) begin
      errors++; $display("FAIL bp_count: got %0d bytes, required 2", ev_q.size());
    end else begin
      checks++;
      if (ev_q[1].data !== b1 || ev_q[1].cyc - ev_q[0].cyc != frame_len + 2) begin
        errors++; $display("FAIL bp_second: got data %h after %0d clocks, required %h after %0d",
          ev_q[1].data, ev_q[1].cyc - ev_q[0].cyc, b1, frame_len + 2);
      end
    end
    frame_len = 10;
  endtask

  task automatic test_timeout();
    ev_q.delete();
    to_q.delete();
    @(negedge clk); #1;
    load(3, 8'h44, 1'b0);
    load_q.delete();
    wait_events(1, 50);
    load(0, 8'h5A, 1'b1);
    load_q.delete();
    wait_events(2, 80);
    wait_idle(200);
    checks++;
    if (ev_q.size() != 2 || to_q.size() != 1) begin
      errors++; $display("FAIL to_counts: got %0d bytes %0d timeouts, required 2 and 1", ev_q.size(), to_q.size());
    end else begin
      checks++;
      if (ev_q[0].req != 3 || ev_q[0].data !== 8'h44) begin
        errors++; $display("FAIL to_first: got req %0d data %h, required req 3 data 44", ev_q[0].req, ev_q[0].data);
      end
      checks++;
      if (to_q[0].cyc != ev_q[0].cyc + frame_len + 1 + LTO) begin
        errors++; $display("FAIL to_timing: got timeout at +%0d, required +%0d", to_q[0].cyc - ev_q[0].cyc, frame_len + 1 + LTO);
      end
      checks++;
      if (to_q[0].grant !== '0) begin
        errors++; $display("FAIL to_grant: got %b, required 0", to_q[0].grant);
      end
      checks++;
      if (ev_q[1].req != 0 || ev_q[1].data !== 8'h5A || ev_q[1].cyc != to_q[0].cyc + 1) begin
        errors++; $display("FAIL to_next: got req %0d data %h at +%0d, required req 0 data 5a at +1",
          ev_q[1].req, ev_q[1].data, ev_q[1].cyc - to_q[0].cyc);
      end
    end
    model_rr = 0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      ev_q.delete();
      @(negedge clk); #1;
      for (int r = 0; r < NREQ; r++) begin
        int np;
        np = (it == 0 && r == 0) ? 1 : int'($urandom_range(0, 2));
        for (int p = 0; p < np; p++) begin
          int nb;
          nb = int'($urandom_range(1, 3));
          for (int b = 0; b < nb; b++) load(r, 8'($urandom_range(0, 255)), b == nb - 1);
        end
      end
      run_model();
      wait_events(exp_q.size(), exp_q.size() * 40 + 100);
      wait_idle(200);
      checks++;
      if (ev_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand_count[%0d]: got %0d bytes, required %0d", it, ev_q.size(), exp_q.size());
      end
      for (int k = 0; k < ev_q.size() && k < exp_q.size(); k++) begin
        checks++;
        if (ev_q[k].req !== exp_q[k].req || ev_q[k].data !== exp_q[k].data || ev_q[k].grant !== (NREQ'(1) << exp_q[k].req)) begin
          errors++; $display("FAIL rand_byte[%0d.%0d]: got req %0d data %h grant %b, required req %0d data %h",
            it, k, ev_q[k].req, ev_q[k].data, ev_q[k].grant, exp_q[k].req, exp_q[k].data);
        end
        if (k > 0) begin
          checks++;
          if (ev_q[k].cyc - ev_q[k-1].cyc != (exp_q[k-1].last ? frame_len + 2 + GAP : frame_len + 2)) begin
            errors++; $display("FAIL rand_spacing[%0d.%0d]: got %0d clocks, required %0d", it, k,
              ev_q[k].cyc - ev_q[k-1].cyc, exp_q[k-1].last ? frame_len + 2 + GAP : frame_len + 2);
          end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    ev_q.delete();
    @(negedge clk); #1;
    load(1, 8'hC3, 1'b1);
    load_q.delete();
    wait_events(1, 50);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, tx_start, tx_data, grant, sched_busy, timeout_err} !== '0) begin
      errors++; $display("FAIL async_reset: got %h without a clock edge, required 0",
        {req_ready, tx_start, tx_data, grant, sched_busy, timeout_err});
    end
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    ev_q.delete();
    model_rr = NREQ - 1;
    load(2, 8'($urandom_range(0, 255)), 1'b1);
    load(0, 8'($urandom_range(0, 255)), 1'b1);
    run_model();
    wait_events(1, 60);
    checks++;
    if (ev_q.size() < 1) begin
      errors++; $display("FAIL rearb_start: got no tx_start after reset, required 1");
    end else begin
      checks++;
      if (ev_q[0].cyc != busy_fall_cyc + 2) begin
        errors++; $display("FAIL rearb_wait: got tx_start %0d clocks after busy fell, required 2", ev_q[0].cyc - busy_fall_cyc);
      end
    end
    wait_events(2, 100);
    wait_idle(200);
    checks++;
    if (ev_q.size() != 2) begin
      errors++; $display("FAIL rearb_count: got %0d bytes, required 2", ev_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (ev_q[k].req !== exp_q[k].req || ev_q[k].data !== exp_q[k].data) begin
          errors++; $display("FAIL rearb_order[%0d]: got req %0d data %h, required req %0d data %h",
            k, ev_q[k].req, ev_q[k].data, exp_q[k].req, exp_q[k].data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_single_byte();
    test_backpressure();
    test_timeout();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
